stdp_weight_update: RTL and testbench
=====================================

STDP_WEIGHT_UPDATE -- requirements
Module: stdp_weight_update

Interface
REQ-001 The module SHALL take parameter N, default 32, as the fixed-point word width.
REQ-002 The module SHALL take parameter Q, default 16, as the fractional bits; timestep fields are Q bits wide.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- apply  in  1  timestep strobe, one cycle wide
- enable_stdp  in  1  permits weight changes
- load  in  1  synchronous load of weight_init
- is_spiking_pre  in  1  presynaptic spike flag, sampled on apply
- is_spiking_post  in  1  postsynaptic spike flag, sampled on apply
- weight_init  in  N  initial weight, signed QN.Q
- m1, b1  in  N each  LTP slope and intercept, signed
- m2, b2  in  N each  LTD slope and intercept, signed
- w_min, w_max  in  N each  weight clamp bounds, signed, w_min <= w_max
- window  in  Q  maximum spike-time difference that produces an update
- weight  out  N  current synaptic weight
- update_valid  out  1  one-cycle pulse when weight changes
- ltp  out  1  1 = last update was potentiation, 0 = depression
- busy  out  1  high when state is not IDLE
- overrun  out  1  sticky flag: an apply was dropped
- timestep  out  Q  free-running timestep counter

Function
REQ-004 Edge E0 with apply=1 in IDLE: capture both spike flags, set event delta, then timestep <= timestep+1 (wraps 2^Q-1 -> 0).
REQ-005 On a post spike with a valid stored pre time, the event SHALL be LTP with delta = timestep - t_pre (mod 2^Q).
REQ-006 On a pre spike with a valid stored post time, the event SHALL be LTD with delta = timestep - t_post (mod 2^Q).
REQ-007 If pre and post spike on the same apply, no event SHALL occur; both stored times are updated.
REQ-008 On every sampled spike, the module SHALL store the pre-increment timestep as t_pre or t_post and set that time's valid bit.
REQ-009 The module SHALL implement the FSM IDLE -> CALC (E0) -> UPD (E1) -> IDLE (E2); apply without spikes still traverses all states.
REQ-010 In CALC, the module SHALL compute prod = m * delta, with delta zero-extended and the product full width, then saturate it to N bits signed.
REQ-011 In CALC, dw SHALL = b - prod, saturated to N bits signed, and registered.
REQ-012 In UPD, if an event exists, enable_stdp=1, delta <= window and dw > 0, weight SHALL change.
REQ-013 On such an update, LTP SHALL set weight <= weight + dw and LTD SHALL set weight <= weight - dw, computed at N+1 bits.
REQ-014 The updated weight SHALL be clamped to [w_min, w_max]; update_valid=1 for the cycle after E2 and ltp SHALL be set.
REQ-015 Latency SHALL be that weight is visible 3 edges after the accepting apply edge (E0, E1, E2).
REQ-016 If the update conditions fail, weight SHALL be unchanged, update_valid SHALL stay 0, and ltp SHALL hold.
REQ-017 An apply asserted while busy=1 SHALL be dropped (no time capture, no counter increment) and SHALL set overrun until reset.
REQ-018 load=1 SHALL set weight <= weight_init in any state and return the FSM to IDLE, aborting a pending update.
REQ-019 If load and apply are both asserted in IDLE, load SHALL win and the apply is dropped without setting overrun.
REQ-020 Spike times and the counter SHALL be unaffected by load.
REQ-021 enable_stdp=0 SHALL still record spike times and advance the counter.

Reset
REQ-022 Asserting rst=0 SHALL immediately set state=IDLE.
REQ-023 Asserting rst=0 SHALL set weight, timestep, t_pre, t_post and dw to 0.
REQ-024 Asserting rst=0 SHALL clear the valid bits, update_valid, ltp, busy and overrun.
REQ-025 Reset mid-operation SHALL abandon the pending update.
REQ-026 The first apply SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-027 LTP: load 0x00008000, b1=0x1000, m1=0x100, pre at t=10, post at t=14 -> delta 4, weight 0x00008C00, update_valid, ltp=1.
REQ-028 LTD: continue with b2=0x1000, m2=0x100, pre at t=16 -> delta 2, weight 0x00007E00, ltp=0.
REQ-029 Clamp/window: w_max=0x00008100 with an LTP dw of 0x0C00 -> weight 0x00008100; delta=window+1 -> no update_valid.
REQ-030 Wrap: t_pre=0xFFFE, post after the counter wraps to 0x0001 -> delta 3, LTP applied.
REQ-031 Hazards: apply on E2 -> dropped, overrun=1, timestep unchanged; same-step pre+post -> no update.
REQ-032 Hazards: enable_stdp=0 -> weight static; rst=0 during CALC -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/stdp_weight_update.sv
`default_nettype none
// ============================================================================
// Module   : stdp_weight_update
// Purpose  : Pair-based STDP engine; signed fixed-point weight with clamp.
// Revision : 1.0  initial release
// ============================================================================
module stdp_weight_update #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         apply,
  input  logic         enable_stdp,
  input  logic         load,
  input  logic         is_spiking_pre,
  input  logic         is_spiking_post,
  input  logic [N-1:0] weight_init,
  input  logic [N-1:0] m1,
  input  logic [N-1:0] b1,
  input  logic [N-1:0] m2,
  input  logic [N-1:0] b2,
  input  logic [N-1:0] w_min,
  input  logic [N-1:0] w_max,
  input  logic [Q-1:0] window,
  output logic [N-1:0] weight,
  output logic         update_valid,
  output logic         ltp,
  output logic         busy,
  output logic         overrun,
  output logic [Q-1:0] timestep
);

  localparam int c_pw = N + Q + 1;
  localparam logic signed [N-1:0] c_smax = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] c_smin = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    UPD  = 2'd2
  } state_t;

  state_t              r_state;
  logic signed [N-1:0] r_weight;
  logic signed [N-1:0] r_dw;
  logic [Q-1:0]        r_timestep;
  logic [Q-1:0]        r_t_pre;
  logic [Q-1:0]        r_t_post;
  logic [Q-1:0]        r_delta;
  logic                r_pre_vld;
  logic                r_post_vld;
  logic                r_evt;
  logic                r_evt_ltp;
  logic                r_update_valid;
  logic                r_ltp;
  logic                r_overrun;

  logic signed [c_pw-1:0] w_m_ext;
  logic signed [c_pw-1:0] w_delta_ext;
  logic signed [c_pw-1:0] w_prod;
  logic signed [N-1:0]    w_prod_sat;
  logic signed [N-1:0]    w_b;
  logic signed [N:0]      w_diff;
  logic signed [N-1:0]    w_dw;
  logic signed [N:0]      w_sum;
  logic signed [N:0]      w_hi;
  logic signed [N:0]      w_lo;
  logic signed [N-1:0]    w_new;
  logic                   w_do_update;
  logic                   w_accept;
  logic                   w_cap_evt;
  logic                   w_cap_ltp;
  logic [Q-1:0]           w_cap_delta;

  // Narrow a full-width product to N bits: in range only if the top Q+2 bits agree.
  function automatic logic signed [N-1:0] sat_prod(input logic signed [c_pw-1:0] v);
    logic [c_pw-N:0] top;
    top = v[c_pw-1:N-1];
    if ((&top) || (~|top)) sat_prod = v[N-1:0];
    else if (v[c_pw-1])    sat_prod = c_smin;
    else                   sat_prod = c_smax;
  endfunction

  function automatic logic signed [N-1:0] sat_n1(input logic signed [N:0] v);
    if (v[N] == v[N-1]) sat_n1 = v[N-1:0];
    else if (v[N])      sat_n1 = c_smin;
    else                sat_n1 = c_smax;
  endfunction

  // Spike capture: simultaneous pre+post yields no pairing event.
  always_comb begin
    w_accept    = apply && !load && (r_state == IDLE);
    w_cap_evt   = (is_spiking_post && !is_spiking_pre && r_pre_vld) ||
                  (is_spiking_pre && !is_spiking_post && r_post_vld);
    w_cap_ltp   = is_spiking_post;
    w_cap_delta = is_spiking_post ? (r_timestep - r_t_pre) : (r_timestep - r_t_post);
  end

  // Rule evaluation: dw = sat(b - sat(m * delta)), delta treated as unsigned.
  always_comb begin
    w_m_ext     = r_evt_ltp ? {{(Q+1){m1[N-1]}}, m1} : {{(Q+1){m2[N-1]}}, m2};
    w_b         = r_evt_ltp ? b1 : b2;
    w_delta_ext = {{(N+1){1'b0}}, r_delta};
    w_prod      = w_m_ext * w_delta_ext;
    w_prod_sat  = sat_prod(w_prod);
    w_diff      = {w_b[N-1], w_b} - {w_prod_sat[N-1], w_prod_sat};
    w_dw        = sat_n1(w_diff);
  end

  always_comb begin
    w_sum = r_evt_ltp ? ({r_weight[N-1], r_weight} + {r_dw[N-1], r_dw})
                      : ({r_weight[N-1], r_weight} - {r_dw[N-1], r_dw});
    w_hi  = {w_max[N-1], w_max};
    w_lo  = {w_min[N-1], w_min};
    if (w_sum > w_hi)      w_new = w_max;
    else if (w_sum < w_lo) w_new = w_min;
    else                   w_new = w_sum[N-1:0];
    w_do_update = r_evt && enable_stdp && (r_delta <= window) &&
                  !r_dw[N-1] && (r_dw != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_weight       <= '0;
      r_dw           <= '0;
      r_timestep     <= '0;
      r_t_pre        <= '0;
      r_t_post       <= '0;
      r_delta        <= '0;
      r_pre_vld      <= 1'b0;
      r_post_vld     <= 1'b0;
      r_evt          <= 1'b0;
      r_evt_ltp      <= 1'b0;
      r_update_valid <= 1'b0;
      r_ltp          <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_update_valid <= 1'b0;
      if (apply && (r_state != IDLE)) r_overrun <= 1'b1;

      if (load) begin
        r_weight <= weight_init;
        r_state  <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_evt      <= w_cap_evt;
              r_evt_ltp  <= w_cap_ltp;
              r_delta    <= w_cap_delta;
              if (is_spiking_pre) begin
                r_t_pre   <= r_timestep;
                r_pre_vld <= 1'b1;
              end
              if (is_spiking_post) begin
                r_t_post   <= r_timestep;
                r_post_vld <= 1'b1;
              end
              r_timestep <= r_timestep + Q'(1);
              r_state    <= CALC;
            end
          end
          CALC: begin
            r_dw    <= w_dw;
            r_state <= UPD;
          end
          UPD: begin
            if (w_do_update) begin
              r_weight       <= w_new;
              r_update_valid <= 1'b1;
              r_ltp          <= r_evt_ltp;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign weight       = r_weight;
  assign update_valid = r_update_valid;
  assign ltp          = r_ltp;
  assign busy         = (r_state != IDLE);
  assign overrun      = r_overrun;
  assign timestep     = r_timestep;

endmodule
`default_nettype wire

// File: tb/tb_stdp_weight_update.sv
`default_nettype none
// ============================================================================
// Module   : tb_stdp_weight_update
// Purpose  : Scoreboard bench for stdp_weight_update against a pairing model.
// Revision : 1.0  initial release
// ============================================================================
module tb_stdp_weight_update;

  localparam int N    = 32;
  localparam int Q    = 12;  // narrower counter so the wrap case is reachable quickly
  localparam int MASK = (1 << Q) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         apply, enable_stdp, load, pre, post;
  logic [N-1:0] weight_init, m1, b1, m2, b2, w_min, w_max;
  logic [Q-1:0] window;
  logic [N-1:0] weight;
  logic         update_valid, ltp, busy, overrun;
  logic [Q-1:0] timestep;

  stdp_weight_update #(.N(N), .Q(Q)) dut (
    .clk(clk), .rst(rst), .apply(apply), .enable_stdp(enable_stdp), .load(load),
    .is_spiking_pre(pre), .is_spiking_post(post), .weight_init(weight_init),
    .m1(m1), .b1(b1), .m2(m2), .b2(b2), .w_min(w_min), .w_max(w_max),
    .window(window), .weight(weight), .update_valid(update_valid), .ltp(ltp),
    .busy(busy), .overrun(overrun), .timestep(timestep)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         uv;
    logic [N-1:0] w;
    logic         l;
    logic [Q-1:0] ts;
    logic         ov;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad   = 0;
  bit     mon_en = 1'b0;
  logic   prev_busy = 1'b0;

  longint m_w;
  int     m_ts, m_tpre, m_tpost;
  bit     m_pv, m_qv, m_ltp, m_ovr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint sat_n(input longint v);
    longint hi = (longint'(1) <<< (N-1)) - 1;
    longint lo = -(longint'(1) <<< (N-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    m_w = 0; m_ts = 0; m_tpre = 0; m_tpost = 0;
    m_pv = 0; m_qv = 0; m_ltp = 0; m_ovr = 0;
  endtask

  // Pairing rule evaluated with plain integer arithmetic; one record per accepted apply.
  task automatic model_apply(input bit p, input bit q, input bit abort, input logic [N-1:0] init);
    bit     evt = 0, isl = 0;
    longint d = 0, m, b, prod, dw, nw;
    exp_t   e;
    if (q && !p && m_pv)      begin evt = 1; isl = 1; d = (m_ts - m_tpre) & MASK; end
    else if (p && !q && m_qv) begin evt = 1; isl = 0; d = (m_ts - m_tpost) & MASK; end
    if (p) begin m_tpre = m_ts; m_pv = 1; end
    if (q) begin m_tpost = m_ts; m_qv = 1; end
    m_ts = (m_ts + 1) & MASK;
    e.uv = 1'b0;
    if (abort) m_w = longint'($signed(init));
    else if (evt && enable_stdp && d <= longint'(window)) begin
      m    = isl ? longint'($signed(m1)) : longint'($signed(m2));
      b    = isl ? longint'($signed(b1)) : longint'($signed(b2));
      prod = sat_n(m * d);
      dw   = sat_n(b - prod);
      if (dw > 0) begin
        nw = isl ? m_w + dw : m_w - dw;
        if (nw > longint'($signed(w_max)))      nw = longint'($signed(w_max));
        else if (nw < longint'($signed(w_min))) nw = longint'($signed(w_min));
        m_w   = nw;
        m_ltp = isl;
        e.uv  = 1'b1;
      end
    end
    e.w  = m_w[N-1:0];
    e.l  = m_ltp;
    e.ts = m_ts[Q-1:0];
    e.ov = m_ovr;
    sb.push_back(e);
  endtask

  // Monitor: every busy->idle transition is one finished transaction.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst || !mon_en) prev_busy = 1'b0;
    else begin
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_completion: weight=%0h uv=%0b", weight, update_valid);
        end else begin
          e = sb.pop_front();
          check("sb_update_valid", update_valid, e.uv);
          check("sb_weight", weight, e.w);
          check("sb_ltp", ltp, e.l);
          check("sb_timestep", timestep, e.ts);
          check("sb_overrun", overrun, e.ov);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic do_apply(input bit p, input bit q);
    @(negedge clk);
    apply = 1'b1; pre = p; post = q;
    model_apply(p, q, 1'b0, '0);
    @(negedge clk);
    apply = 1'b0; pre = 1'b0; post = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic advance_to(input int t);
    while (m_ts != t) do_apply(1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [N-1:0] v);
    @(negedge clk);
    load = 1'b1; weight_init = v;
    @(negedge clk);
    load = 1'b0;
    m_w = longint'($signed(v));
    check("load_weight", weight, v);
  endtask

  function automatic logic [N-1:0] pick_m();
    int k = $urandom_range(0, 5);
    if (k == 0) return 32'h7FFF_FFFF;
    if (k == 1) return 32'h8000_0000;
    return N'(int'($urandom_range(0, 1024)) - 512);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; apply = 0; enable_stdp = 0; load = 0; pre = 0; post = 0;
    weight_init = '0; m1 = '0; b1 = '0; m2 = '0; b2 = '0;
    w_min = '0; w_max = '0; window = '0;
    model_reset();
    #3 rst = 1'b0;
    #1;
    check("rst_weight", weight, 0);
    check("rst_timestep", timestep, 0);
    check("rst_busy", busy, 0);
    check("rst_update_valid", update_valid, 0);
    check("rst_ltp", ltp, 0);
    check("rst_overrun", overrun, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    m1 = 32'h100; b1 = 32'h1000; m2 = 32'h100; b2 = 32'h1000;
    w_min = 32'h0; w_max = 32'h0010_0000; window = 100; enable_stdp = 1'b1;
    do_load(32'h0000_8000);

    // Potentiation then depression with known deltas.
    advance_to(10); do_apply(1, 0);
    advance_to(14); do_apply(0, 1);
    check("ltp_weight", weight, 32'h0000_8C00);
    check("ltp_flag", ltp, 1);
    advance_to(16); do_apply(1, 0);
    check("ltd_weight", weight, 32'h0000_7E00);
    check("ltd_flag", ltp, 0);

    w_max = 32'h0000_8100;
    advance_to(20); do_apply(0, 1);
    check("clamp_weight", weight, 32'h0000_8100);
    w_max = 32'h0010_0000;

    window = 5;
    advance_to(21); do_apply(1, 0);
    advance_to(27); do_apply(0, 1);   // delta 6, outside window
    advance_to(28); do_apply(1, 0);
    advance_to(33); do_apply(0, 1);   // delta 5, exactly on window
    do_apply(1, 1);                   // simultaneous spikes
    enable_stdp = 1'b0;
    do_apply(1, 0);
    do_apply(0, 1);
    enable_stdp = 1'b1;

    // load and apply together in IDLE: load wins, no capture, no overrun
    @(negedge clk);
    load = 1'b1; apply = 1'b1; pre = 1'b1; weight_init = 32'h0000_4000;
    @(negedge clk);
    load = 1'b0; apply = 1'b0; pre = 1'b0;
    m_w = 32'h4000;
    check("loadapply_weight", weight, 32'h0000_4000);
    check("loadapply_timestep", timestep, m_ts[Q-1:0]);
    check("loadapply_busy", busy, 0);
    check("loadapply_overrun", overrun, 0);

    // load during CALC aborts the pending update
    @(negedge clk);
    apply = 1'b1; post = 1'b1;
    model_apply(1'b0, 1'b1, 1'b1, 32'h0000_5000);
    @(negedge clk);
    apply = 1'b0; post = 1'b0; load = 1'b1; weight_init = 32'h0000_5000;
    @(negedge clk);
    load = 1'b0;
    check("abort_weight", weight, 32'h0000_5000);

    // apply arriving on the UPD edge is dropped and flagged
    @(negedge clk);
    apply = 1'b1;
    m_ovr = 1'b1;
    model_apply(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk); apply = 1'b0;
    @(negedge clk); apply = 1'b1;
    @(negedge clk); apply = 1'b0;
    check("overrun_set", overrun, 1);
    check("overrun_timestep", timestep, m_ts[Q-1:0]);

    for (int i = 0; i < 250; i++) begin
      int k;
      if ($urandom_range(0, 7) == 0) begin
        int lo;
        m1 = pick_m(); m2 = pick_m();
        b1 = N'(int'($urandom_range(0, 24576)) - 4096);
        b2 = N'(int'($urandom_range(0, 24576)) - 4096);
        if ($urandom_range(0, 5) == 0) b1 = 32'h7FFF_FFFF;
        lo = int'($urandom_range(0, 98304)) - 65536;
        w_min = N'(lo);
        w_max = N'(lo + int'($urandom_range(0, 131072)));
        window = Q'($urandom_range(0, 8));
        enable_stdp = ($urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 30) == 0) do_load(N'($urandom_range(0, 65535)));
      k = $urandom_range(0, 9);
      if (k < 4)       do_apply(1, 0);
      else if (k < 8)  do_apply(0, 1);
      else if (k == 8) do_apply(1, 1);
      else             do_apply(0, 0);
    end

    // Counter wrap: pre just before wrap, post after it.
    m1 = 32'h100; b1 = 32'h1000; m2 = 32'h100; b2 = 32'h1000;
    w_min = 32'h0; w_max = 32'h0010_0000; window = 100; enable_stdp = 1'b1;
    advance_to(MASK - 1); do_apply(1, 0);
    do_apply(0, 0); do_apply(0, 0);
    do_load(32'h0000_8000);
    do_apply(0, 1);
    check("wrap_weight", weight, 32'h0000_8D00);
    check("wrap_ltp", ltp, 1);
    check("wrap_timestep", timestep, 2);

    // Asynchronous reset while in CALC.
    mon_en = 1'b0;
    @(negedge clk);
    apply = 1'b1; post = 1'b1;
    @(negedge clk);
    apply = 1'b0; post = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_weight", weight, 0);
    check("midrst_timestep", timestep, 0);
    check("midrst_busy", busy, 0);
    check("midrst_update_valid", update_valid, 0);
    check("midrst_ltp", ltp, 0);
    check("midrst_overrun", overrun, 0);
    sb.delete();
    model_reset();

    // First apply on the first edge after release.
    @(negedge clk);
    rst = 1'b1; apply = 1'b1; post = 1'b1;
    mon_en = 1'b1;
    model_apply(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    apply = 1'b0; post = 1'b0;
    @(negedge clk);
    @(negedge clk);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
